// File: rtl/cam_match_iter_if.sv
// Handshake bundle between the CAM compare stage, the multi-match resolver and
// the downstream read/update logic.
interface cam_match_iter_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
);
    logic             match_valid;
    logic [N-1:0]     match_vec;
    logic             match_ready;
    logic             abort;
    logic             hit_valid;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_last;
    logic [IDX_W:0]   hit_ord;
    logic [IDX_W:0]   hit_total;
    logic             miss;
    logic             busy;

    // Resolver side
    modport slave (
        input  match_valid, match_vec, abort, hit_ready,
        output match_ready, hit_valid, hit_idx, hit_last, hit_ord, hit_total, miss, busy
    );

    // Driver / consumer side
    modport master (
        output match_valid, match_vec, abort, hit_ready,
        input  match_ready, hit_valid, hit_idx, hit_last, hit_ord, hit_total, miss, busy
    );
endinterface

// File: rtl/cam_match_iter.sv
// Multi-match resolver: takes one CAM match vector per search and walks every
// set bit, lowest index first, one hit per accepted downstream handshake.
module cam_match_iter #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input logic              clk,
    input logic              rst,
    cam_match_iter_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W:0]   ord_q, ord_d;
    logic [IDX_W:0]   total_q, total_d;
    logic             miss_q, miss_d;

    logic [IDX_W-1:0] enc_idx;
    logic [IDX_W:0]   vec_count;
    logic             single;
    logic             scanning;

    assign scanning = (state_q == SCAN);

    // 16:4 LSB-first priority encode of the pending bits
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    // Popcount of the offered vector, latched as hit_total on acceptance
    always_comb begin
        vec_count = '0;
        for (int i = 0; i < N; i++) begin
            vec_count = vec_count + (IDX_W + 1)'(bus.match_vec[i]);
        end
    end

    // Exactly one pending bit left means the shown hit is the last one
    assign single = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

    assign bus.match_ready = !scanning && !bus.abort;
    assign bus.hit_valid   = scanning;
    assign bus.hit_idx     = scanning ? enc_idx : '0;
    assign bus.hit_last    = scanning && single;
    assign bus.hit_ord     = ord_q;
    assign bus.hit_total   = total_q;
    assign bus.miss        = miss_q;
    assign bus.busy        = scanning;

    // Next-state: accept in IDLE, consume one hit per handshake in SCAN; abort wins
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ord_d     = ord_q;
        total_d   = total_q;
        miss_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.match_valid && !bus.abort) begin
                    if (bus.match_vec == '0) begin
                        miss_d = 1'b1;
                    end else begin
                        pending_d = bus.match_vec;
                        total_d   = vec_count;
                        ord_d     = '0;
                        state_d   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    pending_d = '0;
                    ord_d     = '0;
                    state_d   = IDLE;
                end else if (bus.hit_ready) begin
                    pending_d = pending_q & ~(N'(1) << enc_idx);
                    ord_d     = ord_q + (IDX_W + 1)'(1);
                    if (single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ord_q     <= '0;
            total_q   <= '0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ord_q     <= ord_d;
            total_q   <= total_d;
            miss_q    <= miss_d;
        end
    end

endmodule

// File: tb/tb_cam_match_iter.sv
// Randomized and directed bench for cam_match_iter against a queue-based model.
module tb_cam_match_iter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cam_match_iter_if bus ();

    cam_match_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of indices still to be emitted for the current search
    int exp_q[$];
    int m_ord     = 0;
    int m_total   = 0;
    bit m_miss    = 1'b0;
    bit m_fresh   = 1'b0;
    bit m_known   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare outputs, then advance the model at posedge
    task automatic step(input bit r, input bit v, input logic [15:0] vec, input bit ab,
                        input bit rdy);
        @(negedge clk);
        rst             = r;
        bus.match_valid = v;
        bus.match_vec   = vec;
        bus.abort       = ab;
        bus.hit_ready   = rdy;
        #1;
        if (m_known) begin
            check_eq("miss", bus.miss, m_miss);
            if (exp_q.size() > 0) begin
                check_eq("hit_valid", bus.hit_valid, 1);
                check_eq("hit_idx", bus.hit_idx, exp_q[0]);
                check_eq("hit_last", bus.hit_last, exp_q.size() == 1);
                check_eq("hit_ord", bus.hit_ord, m_ord);
                check_eq("hit_total", bus.hit_total, m_total);
                check_eq("match_ready", bus.match_ready, 0);
                check_eq("busy", bus.busy, 1);
            end else begin
                check_eq("hit_valid", bus.hit_valid, 0);
                check_eq("hit_idx", bus.hit_idx, 0);
                check_eq("hit_last", bus.hit_last, 0);
                check_eq("match_ready", bus.match_ready, !ab);
                check_eq("busy", bus.busy, 0);
                if (m_fresh) begin
                    check_eq("reset_ord", bus.hit_ord, 0);
                    check_eq("reset_total", bus.hit_total, 0);
                end
            end
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_ord   = 0;
            m_total = 0;
            m_miss  = 1'b0;
            m_fresh = 1'b1;
            m_known = 1'b1;
        end else if (exp_q.size() > 0) begin
            m_miss = 1'b0;
            if (ab) begin
                exp_q.delete();
                m_ord = 0;
            end else if (rdy) begin
                void'(exp_q.pop_front());
                m_ord++;
            end
        end else begin
            m_miss = v && !ab && (vec == 16'h0000);
            if (v && !ab && vec != 16'h0000) begin
                for (int i = 0; i < 16; i++) begin
                    if (vec[i]) exp_q.push_back(i);
                end
                m_total = $countones(vec);
                m_ord   = 0;
                m_fresh = 1'b0;
            end
        end
    endtask

    function automatic logic [15:0] rand_vec();
        int unsigned mode;
        logic [15:0] v;
        mode = $urandom_range(0, 5);
        case (mode)
            0: v = 16'h0000;
            1: v = 16'h0001 << $urandom_range(0, 15);
            2: v = 16'hFFFF;
            3: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        bus.match_valid = 1'b0;
        bus.match_vec   = '0;
        bus.abort       = 1'b0;
        bus.hit_ready   = 1'b0;

        // Reset
        step(1, 0, 16'h0000, 0, 0);
        step(1, 0, 16'h0000, 0, 0);
        step(0, 0, 16'h0000, 0, 0);

        // 8421: hits 0,5,10,15 back to back
        step(0, 1, 16'h8421, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);

        // All-zero vector: one-cycle miss
        step(0, 1, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);

        // FFFF with hit_ready toggling: every index held across a stall
        step(0, 1, 16'hFFFF, 0, 1);
        for (int i = 0; i < 32; i++) step(0, 0, 16'h0000, 0, (i % 2) == 0);
        step(0, 0, 16'h0000, 0, 1);

        // 00F0 aborted while idx 5 is shown, then 0002
        step(0, 1, 16'h00F0, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 1, 16'h0002, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);

        // Abort in IDLE blocks acceptance and raises no miss
        step(0, 1, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 0, 1);

        // 0100 then reset during a stall, then 0001
        step(0, 1, 16'h0100, 0, 0);
        step(0, 0, 16'h0000, 0, 0);
        step(1, 0, 16'h0000, 0, 0);
        step(0, 1, 16'h0001, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);

        // match_valid held through a scan of 0003; next vector taken only afterwards
        step(0, 1, 16'h0003, 0, 1);
        step(0, 1, 16'h0005, 0, 1);
        step(0, 1, 16'h0005, 0, 1);
        step(0, 1, 16'h0005, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 rand_vec(),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_match_iter.md
Name: cam_match_iter

Overview:
- Multi-match resolver for the 16-entry CAM. Accepts one 16-bit match vector per search and emits every matching entry index, lowest index first, one per accepted handshake.
- Uses the team's 16:4 LSB priority encoder on an internal pending register, clearing each granted bit after its hit is consumed.
- Sits between the CAM match-line compare stage and the downstream read/update logic.

Parameters:
- N, 16, number of CAM entries. Fixed at 16 to match the 16:4 encoder; other values are unsupported.
- IDX_W, 4, index width, equal to log2(N).

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- match_valid  input  1  match vector offered
- match_vec  input  16  per-entry match lines; bit i = entry i hit
- match_ready  output  1  block idle and able to take a vector
- abort  input  1  synchronous flush of the search in progress
- hit_valid  output  1  hit_idx valid
- hit_ready  input  1  downstream accepts the current hit
- hit_idx  output  4  index of the current hit (lowest pending bit)
- hit_last  output  1  current hit is the final pending match
- hit_ord  output  5  0-based ordinal of the current hit within this search
- hit_total  output  5  popcount of the accepted vector (1..16)
- miss  output  1  one-cycle pulse: accepted vector was all zero
- busy  output  1  state == SCAN

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; pending=0; hit_ord=0; hit_total=0; miss=0.
  - First cycle after reset: hit_valid=0, hit_last=0, hit_idx=0, busy=0, match_ready=1.
  - Reset overrides every other input, including an in-flight search.
- FSM states: IDLE, SCAN.
- IDLE:
  - match_ready = ~abort.
  - Accept on match_valid & match_ready.
  - Accepted vector == 0: miss=1 on the next cycle only; stay in IDLE.
  - Accepted vector != 0: pending <= match_vec; hit_total <= popcount(match_vec); hit_ord <= 0; go to SCAN.
- SCAN:
  - match_ready=0; hit_valid=1.
  - hit_idx = LSB priority encode of pending, combinational from the register.
  - hit_last = (pending has exactly one bit set).
  - On hit_valid & hit_ready: clear pending[hit_idx] and increment hit_ord.
  - If hit_last was 1 at that handshake, go to IDLE instead.
- Latency and throughput:
  - A vector accepted at edge t gives hit_valid=1 in cycle t+1.
  - One hit per cycle while hit_ready=1.
  - A vector with k matches occupies k cycles in SCAN; match_ready returns in the cycle after the last hit is accepted.
  - No overlap: a new vector is never accepted in the same cycle as the last hit.
- Stall: while hit_valid=1 and hit_ready=0, hit_idx, hit_last, hit_ord and hit_total hold stable.
- abort:
  - Takes priority over the hit handshake in the same cycle; that hit is not consumed.
  - Next cycle: state=IDLE, pending=0, hit_ord=0, hit_valid=0.
  - In IDLE, abort blocks acceptance for that cycle (match_ready=0) and emits no miss.
- Width rules:
  - hit_total and hit_ord are 5 bits, covering a maximum total of 16 and a maximum ordinal of 15.
  - hit_ord == hit_total-1 exactly when hit_last=1.
- Changes to match_vec after acceptance are ignored.
- hit_idx is don't-care when hit_valid=0; drive it to 0.

Test Plan:
- Reset, then match_vec=16'h8421 with match_valid=1, hit_ready=1 held high:
  - Hits 0, 5, 10, 15 on 4 consecutive cycles.
  - hit_ord 0..3, hit_total=4, hit_last only on idx 15.
  - match_ready=1 on the following cycle.
- match_vec=16'h0000:
  - miss=1 for exactly one cycle; hit_valid never asserts; match_ready remains 1.
- match_vec=16'hFFFF with hit_ready toggling 1,0,1,0:
  - Indices 0..15 in order, each held stable across its stall cycle.
  - hit_total=16; hit_last at idx 15 with hit_ord=15.
- match_vec=16'h00F0:
  - Accept idx 4, then assert abort together with hit_ready while idx 5 is shown.
  - Idx 5 is not consumed; next cycle hit_valid=0 and match_ready=1.
  - A new vector 16'h0002 then yields idx 1 with hit_ord=0.
- match_vec=16'h0100, then assert rst while hit_valid=1 and hit_ready=0:
  - Next cycle all outputs are at reset values.
  - A subsequent 16'h0001 yields idx 0 with hit_last=1.
- match_valid=1 held continuously during a scan of 16'h0003:
  - match_ready=0 for 2 cycles and the next vector is accepted only afterwards.
  - No vector is lost or double-accepted.
